uart_tx_scheduler: RTL and testbench

Shares a single 8N1 UART transmit line between up to four byte-stream requesters on the DE0-Nano side of the Raspberry Pi link. The block grants requesters round-robin and serializes the granted byte LSB-first onto `txd`. It sequences the external baud tick generator: it drives that generator's `enable` and advances one bit per returned `tick`. It sits between the on-board data producers and the `txd` pin.

---
 rtl/uart_tx_scheduler.sv | 111 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one 8N1 UART transmit line among up to four requesters.
// Gates the external baud generator with baud_en_o and advances one bit per returned tick.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 2,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 baud_en_o,
    input  logic                 baud_tick_i,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic [1:0]           grant_id_o
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] DATA      = 2'd2;
    localparam logic [1:0] STOP      = 2'd3;
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [1:0] LAST_RST  = 2'(NUM_REQ - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic [3:0]  valid4;
    logic [31:0] data32;
    logic [1:0]  cand, win;
    logic        found, xfer;
    logic [7:0]  win_byte;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        valid4 = '0;
        valid4[NUM_REQ-1:0] = req_valid_i;
        data32 = '0;
        data32[8*NUM_REQ-1:0] = req_data_i;
        cand  = last_q;
        win   = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 2'((int'(last_q) + k) % NUM_REQ);
            if (!found && valid4[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_byte = data32[{win, 3'b000} +: 8];
    end

    assign req_ready_o = (state_q == IDLE && found) ? (NUM_REQ'(1) << win) : '0;
    assign xfer        = |(req_valid_i & req_ready_o);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        last_d     = last_q;
        grant_d    = grant_q;
        case (state_q)
            IDLE: if (xfer) begin
                state_d = START;
                shreg_d = win_byte;
                grant_d = win;
                last_d  = win;
            end
            START: if (baud_tick_i) begin
                state_d   = DATA;
                bit_idx_d = 3'd0;
            end
            DATA: if (baud_tick_i) begin
                state_d    = (bit_idx_q == 3'd7) ? STOP : DATA;
                stop_cnt_d = 1'b0;
                bit_idx_d  = bit_idx_q + 3'd1;
            end
            default: if (baud_tick_i) begin
                state_d    = (stop_cnt_q == STOP_LAST) ? IDLE : STOP;
                stop_cnt_d = stop_cnt_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            last_q     <= LAST_RST;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
        end
    end

    assign txd_o      = (state_q == START) ? 1'b0 : (state_q == DATA) ? shreg_q[bit_idx_q] : 1'b1;
    assign baud_en_o  = state_q != IDLE;
    assign busy_o     = state_q != IDLE;
    assign grant_id_o = grant_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: checks two configurations (3 req/1 stop, 2 req/2 stop) against a
// frame-level round-robin reference model, with a behavioural baud generator (tick every 16 clk).
module tb_uart_tx_scheduler;
    logic clk = 0, rst_n = 0;
    logic [2:0]  a_valid = 0, a_ready;
    logic [23:0] a_data = 0;
    logic        a_en, a_tick, a_txd, a_busy, a_inj = 0;
    logic [1:0]  a_gid;
    logic [1:0]  b_valid = 0, b_ready;
    logic [15:0] b_data = 0;
    logic        b_en, b_tick, b_txd, b_busy, b_inj = 0;
    logic [1:0]  b_gid;
    int a_cnt = 0, b_cnt = 0;
    int n_cmp = 0, n_bad = 0;
    logic [1:0] a_last, b_last;

    logic [9:0]  a_cur = 0;
    logic [10:0] b_cur = 0;
    int a_n = 0, b_n = 0, a_dur = 0, b_dur = 0, b_gap = 0;
    logic a_pb = 0, b_pb = 0;
    logic [10:0] a_frq[$], b_frq[$];
    logic [1:0]  a_gq[$], b_gq[$];
    int a_durq[$], b_durq[$], b_gapq[$];

    uart_tx_scheduler #(.NUM_REQ(3), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid_i(a_valid), .req_data_i(a_data),
        .req_ready_o(a_ready), .baud_en_o(a_en), .baud_tick_i(a_tick),
        .txd_o(a_txd), .busy_o(a_busy), .grant_id_o(a_gid));

    uart_tx_scheduler #(.NUM_REQ(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid_i(b_valid), .req_data_i(b_data),
        .req_ready_o(b_ready), .baud_en_o(b_en), .baud_tick_i(b_tick),
        .txd_o(b_txd), .busy_o(b_busy), .grant_id_o(b_gid));

    initial forever #5 clk = ~clk;

    // Baud generator: held while disabled, so the first tick lands one full bit after enable.
    always @(posedge clk) a_cnt <= a_en ? ((a_cnt == 15) ? 0 : a_cnt + 1) : 0;
    always @(posedge clk) b_cnt <= b_en ? ((b_cnt == 15) ? 0 : b_cnt + 1) : 0;
    assign a_tick = (a_en && a_cnt == 15) || a_inj;
    assign b_tick = (b_en && b_cnt == 15) || b_inj;

    // Line monitors: sample txd at every tick of a frame, log frame, grant, busy width and idle gap.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_n <= 0; a_dur <= 0; a_pb <= 0;
        end else begin
            if (a_busy && a_tick) begin
                if (a_n == 9) begin
                    a_frq.push_back({1'b0, a_txd, a_cur[8:0]});
                    a_gq.push_back(a_gid);
                    a_n <= 0;
                end else begin
                    a_cur[a_n] <= a_txd;
                    a_n <= a_n + 1;
                end
            end
            if (a_busy) a_dur <= a_dur + 1;
            else if (a_pb) begin a_durq.push_back(a_dur); a_dur <= 0; end
            a_pb <= a_busy;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_n <= 0; b_dur <= 0; b_pb <= 0; b_gap <= 0;
        end else begin
            if (b_busy && b_tick) begin
                if (b_n == 10) begin
                    b_frq.push_back({b_txd, b_cur[9:0]});
                    b_gq.push_back(b_gid);
                    b_n <= 0;
                end else begin
                    b_cur[b_n] <= b_txd;
                    b_n <= b_n + 1;
                end
            end
            if (b_busy) b_dur <= b_dur + 1;
            else if (b_pb) begin b_durq.push_back(b_dur); b_dur <= 0; end
            if (b_busy && !b_pb) begin b_gapq.push_back(b_gap); b_gap <= 0; end
            else if (!b_en) b_gap <= b_gap + 1;
            b_pb <= b_busy;
        end
    end

    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] valid, input int n);
        for (int k = 1; k <= n; k++)
            if (valid[(int'(last) + k) % n]) return 2'((int'(last) + k) % n);
        return last;
    endfunction

    task automatic wait_a_busy(input logic lvl);
        for (int i = 0; i < 300 && a_busy !== lvl; i++) @(negedge clk);
        if (a_busy !== lvl) begin n_cmp++; n_bad++; $display("FAIL timeout_a_busy got %b want %b", a_busy, lvl); end
    endtask

    task automatic wait_b_busy(input logic lvl);
        for (int i = 0; i < 300 && b_busy !== lvl; i++) @(negedge clk);
        if (b_busy !== lvl) begin n_cmp++; n_bad++; $display("FAIL timeout_b_busy got %b want %b", b_busy, lvl); end
    endtask

    task automatic wait_a_frames(input int n);
        for (int i = 0; i < 200 * n && a_frq.size() < n; i++) @(negedge clk);
        if (a_frq.size() < n) begin n_cmp++; n_bad++; $display("FAIL timeout_a_frames got %0d want %0d", a_frq.size(), n); end
    endtask

    task automatic wait_b_frames(input int n);
        for (int i = 0; i < 200 * n && b_frq.size() < n; i++) @(negedge clk);
        if (b_frq.size() < n) begin n_cmp++; n_bad++; $display("FAIL timeout_b_frames got %0d want %0d", b_frq.size(), n); end
    endtask

    task automatic drain_a;
        a_valid = 0;
        wait_a_busy(0);
        @(negedge clk);
        a_frq.delete(); a_gq.delete(); a_durq.delete();
    endtask

    task automatic do_reset;
        a_valid = 0; b_valid = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
        a_frq.delete(); a_gq.delete(); a_durq.delete();
        b_frq.delete(); b_gq.delete(); b_durq.delete(); b_gapq.delete();
        a_last = 2'd2; b_last = 2'd1;
    endtask

    task automatic test_reset;
        rst_n = 0; a_valid = 0; b_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({a_txd, a_en, a_busy, a_ready, a_gid} !== {1'b1, 1'b0, 1'b0, 3'b000, 2'b00}) begin
            n_bad++; $display("FAIL reset_a got %b want %b", {a_txd, a_en, a_busy, a_ready, a_gid}, 8'b10000000);
        end
        n_cmp++;
        if ({b_txd, b_en, b_busy, b_ready, b_gid} !== {1'b1, 1'b0, 1'b0, 2'b00, 2'b00}) begin
            n_bad++; $display("FAIL reset_b got %b want %b", {b_txd, b_en, b_busy, b_ready, b_gid}, 7'b1000000);
        end
        rst_n = 1;
        a_last = 2'd2; b_last = 2'd1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a_inj = (i % 7 == 3);
            b_inj = (i % 7 == 3);
            #1;
            n_cmp++;
            if ({a_txd, a_en, a_busy, a_ready, b_txd, b_en, b_busy, b_ready} !==
                {1'b1, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00}) begin
                n_bad++;
                $display("FAIL idle_hold cycle %0d got %b want %b", i,
                         {a_txd, a_en, a_busy, a_ready, b_txd, b_en, b_busy, b_ready}, 11'b10000010000);
            end
        end
        a_inj = 0; b_inj = 0;
        n_cmp++;
        if (a_frq.size() + b_frq.size() != 0) begin
            n_bad++; $display("FAIL idle_frames got %0d want 0", a_frq.size() + b_frq.size());
        end
    endtask

    task automatic test_a5;
        logic [10:0] fr;
        logic [1:0]  g;
        int d;
        @(negedge clk);
        a_data = 24'h0000A5; a_valid = 3'b001;
        #1;
        n_cmp++;
        if (a_ready !== 3'b001) begin n_bad++; $display("FAIL a5_ready got %b want 001", a_ready); end
        @(posedge clk); #1;
        a_valid = 0;
        n_cmp++;
        if ({a_ready, a_busy, a_en, a_txd} !== {3'b000, 1'b1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL a5_accept got %b want 000110", {a_ready, a_busy, a_en, a_txd});
        end
        wait_a_frames(1);
        wait_a_busy(0);
        @(negedge clk);
        fr = (a_frq.size() > 0) ? a_frq.pop_front() : 'x;
        g  = (a_gq.size() > 0) ? a_gq.pop_front() : 'x;
        d  = (a_durq.size() > 0) ? a_durq.pop_front() : -1;
        n_cmp++;
        if (fr !== {2'b01, 8'hA5, 1'b0}) begin n_bad++; $display("FAIL a5_frame got %b want %b", fr, {2'b01, 8'hA5, 1'b0}); end
        n_cmp++;
        if (g !== 2'd0) begin n_bad++; $display("FAIL a5_grant got %0d want 0", g); end
        n_cmp++;
        if (d != 160) begin n_bad++; $display("FAIL a5_busy_len got %0d want 160", d); end
        a_last = 2'd0;
    endtask

    task automatic test_round_robin;
        logic [10:0] fr;
        logic [1:0]  g, w;
        do_reset();
        a_data = 24'h332211; a_valid = 3'b111;
        wait_a_frames(6);
        for (int f = 0; f < 6; f++) begin
            w  = rr_pick(a_last, 4'b0111, 3);
            fr = (a_frq.size() > 0) ? a_frq.pop_front() : 'x;
            g  = (a_gq.size() > 0) ? a_gq.pop_front() : 'x;
            n_cmp++;
            if (g !== w) begin n_bad++; $display("FAIL rr_grant frame %0d got %0d want %0d", f, g, w); end
            n_cmp++;
            if (fr !== {2'b01, a_data[8*w +: 8], 1'b0}) begin
                n_bad++; $display("FAIL rr_frame frame %0d got %b want %b", f, fr, {2'b01, a_data[8*w +: 8], 1'b0});
            end
            a_last = w;
        end
        drain_a();
    endtask

    task automatic test_data_hold;
        logic [10:0] fr;
        logic [1:0]  g;
        do_reset();
        a_data = 24'h003C00; a_valid = 3'b010;
        wait_a_busy(1);
        a_valid = 0;
        repeat (50) @(negedge clk);
        a_data[15:8] = 8'hFF;
        wait_a_frames(1);
        fr = (a_frq.size() > 0) ? a_frq.pop_front() : 'x;
        g  = (a_gq.size() > 0) ? a_gq.pop_front() : 'x;
        n_cmp++;
        if (fr !== {2'b01, 8'h3C, 1'b0}) begin n_bad++; $display("FAIL hold_frame got %b want %b", fr, {2'b01, 8'h3C, 1'b0}); end
        n_cmp++;
        if (g !== rr_pick(2'd2, 4'b0010, 3)) begin n_bad++; $display("FAIL hold_grant got %0d want 1", g); end
        a_last = 2'd1;
        drain_a();
    endtask

    task automatic test_random;
        logic [10:0] fr;
        logic [1:0]  g, w;
        logic [2:0]  mask;
        for (int r = 0; r < 8; r++) begin
            wait_a_busy(0);
            @(negedge clk);
            mask = 3'($urandom_range(1, 7));
            a_data = 24'($urandom);
            a_valid = mask;
            #1;
            w = rr_pick(a_last, {1'b0, mask}, 3);
            n_cmp++;
            if (a_ready !== (3'b001 << w)) begin
                n_bad++; $display("FAIL rand_ready round %0d got %b want %b", r, a_ready, 3'b001 << w);
            end
            wait_a_busy(1);
            a_valid = 0;
            wait_a_frames(1);
            fr = (a_frq.size() > 0) ? a_frq.pop_front() : 'x;
            g  = (a_gq.size() > 0) ? a_gq.pop_front() : 'x;
            n_cmp++;
            if (g !== w || fr !== {2'b01, a_data[8*w +: 8], 1'b0}) begin
                n_bad++; $display("FAIL rand_frame round %0d got g=%0d %b want g=%0d %b", r, g, fr, w, {2'b01, a_data[8*w +: 8], 1'b0});
            end
            a_last = w;
        end
        drain_a();
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] fr;
        logic [1:0]  g, w;
        @(negedge clk);
        a_data = 24'($urandom); a_valid = 3'b100;
        wait_a_busy(1);
        a_valid = 0;
        for (int i = 0; i < 300 && a_n != 5; i++) @(negedge clk);
        n_cmp++;
        if (a_n != 5) begin n_bad++; $display("FAIL mid_reach_bit4 got %0d want 5", a_n); end
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({a_txd, a_en, a_busy, a_ready} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
            n_bad++; $display("FAIL mid_async_reset got %b want 100000", {a_txd, a_en, a_busy, a_ready});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        drain_a();
        a_last = 2'd2;
        @(negedge clk);
        a_data = 24'($urandom); a_valid = 3'b111;
        #1;
        w = rr_pick(a_last, 4'b0111, 3);
        n_cmp++;
        if (a_ready !== (3'b001 << w)) begin n_bad++; $display("FAIL mid_ready got %b want %b", a_ready, 3'b001 << w); end
        wait_a_busy(1);
        a_valid = 0;
        wait_a_frames(1);
        fr = (a_frq.size() > 0) ? a_frq.pop_front() : 'x;
        g  = (a_gq.size() > 0) ? a_gq.pop_front() : 'x;
        n_cmp++;
        if (g !== w || fr !== {2'b01, a_data[8*w +: 8], 1'b0}) begin
            n_bad++; $display("FAIL mid_frame got g=%0d %b want g=%0d %b", g, fr, w, {2'b01, a_data[8*w +: 8], 1'b0});
        end
        drain_a();
    endtask

    task automatic test_stop2;
        logic [10:0] fr;
        logic [1:0]  g, w;
        int d, gap;
        do_reset();
        b_data = 16'h0000; b_valid = 2'b11;
        wait_b_busy(1);
        b_valid = 2'b10;
        for (int i = 0; i < 400 && b_gapq.size() < 2; i++) @(negedge clk);
        b_valid = 0;
        wait_b_frames(2);
        wait_b_busy(0);
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            w  = rr_pick(b_last, 4'b0011, 2);
            fr = (b_frq.size() > 0) ? b_frq.pop_front() : 'x;
            g  = (b_gq.size() > 0) ? b_gq.pop_front() : 'x;
            n_cmp++;
            if (g !== w || fr !== {2'b11, 8'h00, 1'b0}) begin
                n_bad++; $display("FAIL stop2_frame %0d got g=%0d %b want g=%0d %b", f, g, fr, w, {2'b11, 8'h00, 1'b0});
            end
            b_last = w;
        end
        d = (b_durq.size() > 0) ? b_durq[0] : -1;
        n_cmp++;
        if (d != 176) begin n_bad++; $display("FAIL stop2_busy_len got %0d want 176", d); end
        gap = (b_gapq.size() > 1) ? b_gapq[1] : -1;
        n_cmp++;
        if (gap < 1) begin n_bad++; $display("FAIL stop2_idle_gap got %0d want >=1", gap); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_a5();
        test_round_robin();
        test_data_hold();
        test_random();
        test_reset_mid_frame();
        test_stop2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
